// File: rtl/fwd_pkg.sv
// Shared opcode encodings and the history-slot record used by the
// decode-stage forwarding / load-use hazard unit.
package fwd_pkg;

    localparam logic [1:0] OP_ALU  = 2'b11;
    localparam logic [1:0] OP_LD   = 2'b00;
    localparam logic [1:0] OP_ST   = 2'b01;
    localparam logic [4:0] OP_LI   = 5'b10000;
    localparam logic [4:0] OP_ADDI = 5'b10001;

    localparam logic [3:0] ALU_CMP = 4'b0101;
    localparam logic [3:0] ALU_OUT = 4'b0111;

    // Register fields are fixed 3-bit slices of the instruction word.
    localparam int REG_W = 3;

    typedef struct packed {
        logic             wr;
        logic [REG_W-1:0] dest;
        logic             is_load;
    } hist_slot_t;

endpackage

// File: rtl/instr_class_dec.sv
// Combinational classifier: which registers an instruction reads and writes,
// and whether its result arrives late (load).
module instr_class_dec
    import fwd_pkg::*;
(
    input  logic [15:0]      instr,
    output logic             wr,
    output logic [REG_W-1:0] dest,
    output logic             is_load,
    output logic             uses_a,
    output logic [REG_W-1:0] src_a,
    output logic             uses_b,
    output logic [REG_W-1:0] src_b
);

    logic       is_alu, is_ld, is_st, is_li, is_addi;
    logic [3:0] op3;

    always_comb begin
        is_alu  = (instr[15:14] == OP_ALU);
        is_ld   = (instr[15:14] == OP_LD);
        is_st   = (instr[15:14] == OP_ST);
        is_li   = (instr[15:11] == OP_LI);
        is_addi = (instr[15:11] == OP_ADDI);
        op3     = instr[7:4];

        // ALU results exist for op3 up to 1100, except compare and output.
        wr = (is_alu && op3 <= 4'b1100 && op3 != ALU_CMP && op3 != ALU_OUT)
             || is_li || is_addi || is_ld;
        dest    = is_ld ? instr[13:11] : instr[10:8];
        is_load = is_ld;

        src_a  = instr[13:11];
        uses_a = (is_alu && (op3 <= 4'b0110 || op3 == 4'b1101)) || is_st;

        src_b  = instr[10:8];
        uses_b = (is_alu && (op3 <= 4'b0101 || (op3 >= 4'b1000 && op3 <= 4'b1011)))
                 || is_ld || is_st || is_addi;
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Decode-stage forwarding selector and load-use stall generator with its own
// history of the last FWD_DEPTH issued instructions.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int FWD_DEPTH = 2,
    parameter int IW        = 16,
    parameter int RAW       = 3,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid,
    input  logic [IW-1:0]        instr,
    input  logic                 hold,
    input  logic                 flush,
    output logic [FWD_DEPTH-1:0] fwd_a,
    output logic [FWD_DEPTH-1:0] fwd_b,
    output logic                 stall,
    output logic                 issue_valid,
    output logic [CNT_W-1:0]     stall_cnt
);

    logic           dec_wr, dec_is_load, uses_a, uses_b;
    logic [RAW-1:0] dec_dest, src_a, src_b;

    instr_class_dec u_dec (
        .instr   (instr[15:0]),
        .wr      (dec_wr),
        .dest    (dec_dest),
        .is_load (dec_is_load),
        .uses_a  (uses_a),
        .src_a   (src_a),
        .uses_b  (uses_b),
        .src_b   (src_b)
    );

    hist_slot_t hist [FWD_DEPTH];
    hist_slot_t new_slot;

    logic [FWD_DEPTH-1:0] match_a, match_b, cand_a, cand_b;
    logic                 found_a, found_b;

    always_comb begin
        for (int k = 0; k < FWD_DEPTH; k++) begin
            match_a[k] = hist[k].wr && (hist[k].dest == src_a) && uses_a && instr_valid;
            match_b[k] = hist[k].wr && (hist[k].dest == src_b) && uses_b && instr_valid;
        end

        stall       = instr_valid && hist[0].is_load && (match_a[0] || match_b[0]);
        issue_valid = instr_valid && !stall && !hold;

        // A load's data is not ready at distance 1; fall back to older producers.
        cand_a = match_a;
        cand_b = match_b;
        if (stall) begin
            cand_a[0] = 1'b0;
            cand_b[0] = 1'b0;
        end

        // Nearest producer wins.
        fwd_a   = '0;
        fwd_b   = '0;
        found_a = 1'b0;
        found_b = 1'b0;
        for (int k = 0; k < FWD_DEPTH; k++) begin
            if (cand_a[k] && !found_a) begin
                fwd_a[k] = 1'b1;
                found_a  = 1'b1;
            end
            if (cand_b[k] && !found_b) begin
                fwd_b[k] = 1'b1;
                found_b  = 1'b1;
            end
        end

        new_slot = '0;
        if (issue_valid) begin
            new_slot.wr      = dec_wr;
            new_slot.dest    = dec_dest;
            new_slot.is_load = dec_is_load;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < FWD_DEPTH; k++) hist[k] <= '0;
        end else if (flush) begin
            for (int k = 0; k < FWD_DEPTH; k++) hist[k] <= '0;
        end else if (!hold) begin
            // Issue, stall and idle all shift; only issue inserts a real entry.
            for (int k = FWD_DEPTH - 1; k > 0; k--) hist[k] <= hist[k-1];
            hist[0] <= new_slot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && !hold && !flush && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: a depth-2 instance and a depth-3 instance
// with a 3-bit stall counter share one input stream.
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = '0;
    logic        hold = 1'b0;
    logic        flush = 1'b0;

    logic [1:0]  fa2, fb2;
    logic        st2, iv2;
    logic [15:0] cnt2;
    logic [2:0]  fa3, fb3;
    logic        st3, iv3;
    logic [2:0]  cnt3;

    int total = 0;
    int bad   = 0;
    int e2, e3;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.FWD_DEPTH(2), .IW(16), .RAW(3), .CNT_W(16)) dut2 (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .hold(hold), .flush(flush), .fwd_a(fa2), .fwd_b(fb2), .stall(st2),
        .issue_valid(iv2), .stall_cnt(cnt2)
    );

    fwd_hazard_unit #(.FWD_DEPTH(3), .IW(16), .RAW(3), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .hold(hold), .flush(flush), .fwd_a(fa3), .fwd_b(fb3), .stall(st3),
        .issue_valid(iv3), .stall_cnt(cnt3)
    );

    function automatic logic [15:0] alu(input logic [3:0] op3, input logic [2:0] a, input logic [2:0] b);
        return {2'b11, a, b, op3, 4'b0000};
    endfunction

    function automatic logic [15:0] ld(input logic [2:0] d, input logic [2:0] b);
        return {2'b00, d, b, 8'h00};
    endfunction

    function automatic logic [15:0] li(input logic [2:0] d);
        return {5'b10000, d, 8'h00};
    endfunction

    // Commit the previous step at the rising edge, then present new inputs.
    task automatic apply(input logic v, input logic [15:0] ins, input logic h, input logic f);
        @(posedge clk);
        #1;
        instr_valid = v;
        instr       = ins;
        hold        = h;
        flush       = f;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    localparam logic [15:0] NOP = 16'b11_000_000_1110_0000;

    initial begin
        // Reset with a valid instruction waiting.
        apply(1'b1, NOP, 1'b0, 1'b0);
        chk("rst_fa2", 32'(fa2), 32'd0);
        chk("rst_fb2", 32'(fb2), 32'd0);
        chk("rst_stall", 32'(st2), 32'd0);
        chk("rst_iv", 32'(iv2), 32'd1);
        chk("rst_cnt2", 32'(cnt2), 32'd0);
        chk("rst_cnt3", 32'(cnt3), 32'd0);
        apply(1'b1, NOP, 1'b1, 1'b0);
        chk("rst_iv_hold", 32'(iv2), 32'd0);
        rst = 1'b0;

        // Distance-1 forwarding on operand A.
        apply(1'b1, alu(4'd0, 3'd0, 3'd1), 1'b0, 1'b0);
        chk("add1_fa2", 32'(fa2), 32'd0);
        chk("add1_iv", 32'(iv2), 32'd1);
        apply(1'b1, alu(4'd0, 3'd1, 3'd2), 1'b0, 1'b0);
        chk("d1_fa2", 32'(fa2), 32'b01);
        chk("d1_fb2", 32'(fb2), 32'b00);
        chk("d1_stall", 32'(st2), 32'd0);
        chk("d1_fa3", 32'(fa3), 32'b001);

        // Distance-2 forwarding on operand B across a non-writer.
        apply(1'b1, li(3'd3), 1'b0, 1'b0);
        chk("li3_fa2", 32'(fa2), 32'd0);
        chk("li3_fb2", 32'(fb2), 32'd0);
        apply(1'b1, NOP, 1'b0, 1'b0);
        apply(1'b1, alu(4'd8, 3'd0, 3'd3), 1'b0, 1'b0);
        chk("d2_fb2", 32'(fb2), 32'b10);
        chk("d2_fa2", 32'(fa2), 32'b00);
        chk("d2_fb3", 32'(fb3), 32'b010);

        // Two producers of r2: the nearest wins.
        apply(1'b1, li(3'd2), 1'b0, 1'b0);
        apply(1'b1, li(3'd2), 1'b0, 1'b0);
        apply(1'b1, alu(4'd13, 3'd2, 3'd0), 1'b0, 1'b0);
        chk("near_fa2", 32'(fa2), 32'b01);
        chk("near_fa3", 32'(fa3), 32'b001);
        chk("near_fb2", 32'(fb2), 32'b00);

        // Load-use: one bubble, then forward from distance 2.
        apply(1'b1, ld(3'd4, 3'd0), 1'b0, 1'b0);
        chk("ld_fb2", 32'(fb2), 32'd0);
        chk("ld_iv", 32'(iv2), 32'd1);
        apply(1'b1, alu(4'd0, 3'd0, 3'd4), 1'b0, 1'b0);
        chk("lu_stall", 32'(st2), 32'd1);
        chk("lu_iv", 32'(iv2), 32'd0);
        chk("lu_fb2", 32'(fb2), 32'b00);
        chk("lu_cnt_pre", 32'(cnt2), 32'd0);
        apply(1'b1, alu(4'd0, 3'd0, 3'd4), 1'b0, 1'b0);
        chk("lu2_stall", 32'(st2), 32'd0);
        chk("lu2_fb2", 32'(fb2), 32'b10);
        chk("lu2_fb3", 32'(fb3), 32'b010);
        chk("lu2_iv", 32'(iv2), 32'd1);
        chk("lu2_cnt2", 32'(cnt2), 32'd1);
        chk("lu2_cnt3", 32'(cnt3), 32'd1);

        // Flush wipes the producer of r5.
        apply(1'b1, li(3'd5), 1'b0, 1'b0);
        apply(1'b1, NOP, 1'b0, 1'b1);
        apply(1'b1, alu(4'd0, 3'd5, 3'd5), 1'b0, 1'b0);
        chk("flush_fa2", 32'(fa2), 32'd0);
        chk("flush_fb2", 32'(fb2), 32'd0);

        // Hold for three cycles freezes history.
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, alu(4'd0, 3'd5, 3'd0), 1'b1, 1'b0);
            chk("hold_fa2", 32'(fa2), 32'b01);
            chk("hold_iv", 32'(iv2), 32'd0);
        end
        apply(1'b1, alu(4'd0, 3'd5, 3'd0), 1'b0, 1'b0);
        chk("rel_fa2", 32'(fa2), 32'b01);
        chk("rel_iv", 32'(iv2), 32'd1);

        // Distance 3: only the depth-3 instance forwards.
        apply(1'b1, li(3'd6), 1'b0, 1'b0);
        apply(1'b0, NOP, 1'b0, 1'b0);
        chk("idle_iv", 32'(iv2), 32'd0);
        apply(1'b0, NOP, 1'b0, 1'b0);
        apply(1'b1, alu(4'd13, 3'd6, 3'd0), 1'b0, 1'b0);
        chk("d3_fa3", 32'(fa3), 32'b100);
        chk("d3_fa2", 32'(fa2), 32'b00);

        // Repeated load-use stalls, each first held for a cycle; counter saturates.
        e2 = 1;
        e3 = 1;
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, ld(3'd7, 3'd0), 1'b0, 1'b0);
            chk("sat_ld_stall", 32'(st2), 32'd0);
            apply(1'b1, alu(4'd0, 3'd7, 3'd0), 1'b1, 1'b0);
            chk("sat_hold_stall", 32'(st3), 32'd1);
            chk("sat_hold_iv", 32'(iv3), 32'd0);
            apply(1'b1, alu(4'd0, 3'd7, 3'd0), 1'b0, 1'b0);
            chk("sat_stall", 32'(st2), 32'd1);
            chk("sat_cnt3_pre", 32'(cnt3), 32'(e3));
            e2 = e2 + 1;
            e3 = (e3 == 7) ? 7 : e3 + 1;
            apply(1'b1, alu(4'd0, 3'd7, 3'd0), 1'b0, 1'b0);
            chk("sat_after_stall", 32'(st2), 32'd0);
            chk("sat_after_fa2", 32'(fa2), 32'b10);
            chk("sat_cnt2", 32'(cnt2), 32'(e2));
            chk("sat_cnt3", 32'(cnt3), 32'(e3));
        end
        chk("sat_final", 32'(cnt3), 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
